// File: rtl/reg_load_arbiter.sv
// Round-robin load/clear sequencer for one shared falling-edge register.
// Loads are confirmed by reading the register back one cycle after capture.
module reg_load_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_REQ    = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic                     ClkN,
  input  logic                     Clr,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     clr_req,
  input  logic [WIDTH-1:0]         register_q,
  output logic [WIDTH-1:0]         new_data,
  output logic                     Enbar,
  output logic                     ClrN,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     clr_done,
  output logic                     err,
  output logic                     busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, CLEAR} state_e;

  state_e             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      win_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   new_data_q;
  logic               enbar_q;
  logic               clrn_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               clr_done_q;
  logic               err_q;
  logic               busy_q;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic [PW-1:0]      scan_idx;
  logic [PW-1:0]      pick_idx;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_oh;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan downward in distance from the pointer so the closest requester
  // (searching upward with wrap) is the last one to write pick_idx.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    pick_oh  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
    pick_oh[pick_idx] = 1'b1;
  end

  always_ff @(negedge ClkN) begin
    if (Clr) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      new_data_q <= '0;
      enbar_q    <= 1'b1;
      clrn_q     <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      clr_done_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q     <= '0;
      clr_done_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          clrn_q <= 1'b1;
          if (clr_req) begin
            state_q <= CLEAR;
            clrn_q  <= 1'b0;
            cnt_q   <= CW'(CLR_CYCLES - 1);
            busy_q  <= 1'b1;
          end else if (pick_vld) begin
            state_q    <= LOAD;
            gnt_q      <= pick_oh;
            win_q      <= pick_idx;
            new_data_q <= data_arr[pick_idx];
            enbar_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          enbar_q <= 1'b1;
          state_q <= VERIFY;
        end
        VERIFY: begin
          if (register_q == new_data_q) done_q <= gnt_q;
          else                          err_q  <= 1'b1;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= IDLE;
        end
        CLEAR: begin
          if (cnt_q == '0) begin
            clrn_q     <= 1'b1;
            clr_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign new_data = new_data_q;
  assign Enbar    = enbar_q;
  assign ClrN     = clrn_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign clr_done = clr_done_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: models the shared falling-edge register and
// predicts grants from the round-robin rule, with directed and random steps.
module tb_reg_load_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CC = 2;

  logic           ClkN;
  logic           Clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           clr_req;
  logic [W-1:0]   register_q;
  logic [W-1:0]   new_data;
  logic           Enbar;
  logic           ClrN;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           clr_done;
  logic           err;
  logic           busy;

  logic [W-1:0]   reg_m;
  logic           force_en;
  logic [W-1:0]   force_val;

  int n_checks;
  int n_err;
  int ptr_m;

  reg_load_arbiter #(.WIDTH(W), .NUM_REQ(N), .CLR_CYCLES(CC)) dut (
    .ClkN(ClkN), .Clr(Clr), .req(req), .req_data(req_data), .clr_req(clr_req),
    .register_q(register_q), .new_data(new_data), .Enbar(Enbar), .ClrN(ClrN),
    .gnt(gnt), .done(done), .clr_done(clr_done), .err(err), .busy(busy)
  );

  // clock/reset block: falling edge is the active edge
  initial ClkN = 1'b1;
  always #5 ClkN = ~ClkN;

  // shared register: synchronous active-low clear over active-low load
  always @(negedge ClkN) begin
    if (ClrN === 1'b0)       reg_m <= '0;
    else if (Enbar === 1'b0) reg_m <= new_data;
  end
  assign register_q = force_en ? force_val : reg_m;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge ClkN);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  function automatic logic [W-1:0] dat_of(input int i);
    return req_data[i*W +: W];
  endfunction

  // round-robin rule: first set bit at or above the pointer, wrapping
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // driver task: one load from the IDLE decision edge to the done/err edge
  task automatic do_load(input int w, input logic [W-1:0] d, input bit bad,
                         input logic [N-1:0] extra);
    logic [N-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    cyc();
    chk("grant", gnt, oh);
    chk("enbar_low", Enbar, 1'b0);
    chk("clrn_during_load", ClrN, 1'b1);
    chk("new_data", new_data, d);
    chk("busy_load", busy, 1'b1);
    chk("clr_done_quiet", clr_done, 1'b0);
    if (bad) begin
      force_en  = 1'b1;
      force_val = ~d;
    end
    req = req | extra;
    cyc();
    chk("enbar_high", Enbar, 1'b1);
    chk("done_early", done, '0);
    chk("gnt_hold", gnt, oh);
    if (!bad) chk("readback", register_q, d);
    cyc();
    chk("done", done, bad ? '0 : oh);
    chk("err", err, bad);
    chk("gnt_clear", gnt, '0);
    chk("busy_end", busy, 1'b0);
    force_en = 1'b0;
    req[w]   = 1'b0;
    ptr_m    = (w + 1) % N;
  endtask

  // driver task: a clear from the IDLE decision edge to the clr_done edge
  task automatic do_clear();
    cyc();
    chk("clr_clrn_low", ClrN, 1'b0);
    chk("clr_busy", busy, 1'b1);
    chk("clr_enbar", Enbar, 1'b1);
    chk("clr_gnt", gnt, '0);
    clr_req = 1'b0;
    for (int k = 1; k < CC; k++) begin
      cyc();
      chk("clr_hold", ClrN, 1'b0);
      chk("clr_done_early", clr_done, 1'b0);
      chk("clr_reg_zero", register_q, '0);
    end
    cyc();
    chk("clr_release", ClrN, 1'b1);
    chk("clr_done", clr_done, 1'b1);
    chk("clr_busy_end", busy, 1'b0);
    chk("clr_reg_after", register_q, '0);
  endtask

  initial begin
    int w;
    bit do_clr;
    bit allow_extra;
    logic [N-1:0] ex;

    n_checks  = 0;
    n_err     = 0;
    ptr_m     = 0;
    Clr       = 1'b1;
    req       = '0;
    clr_req   = 1'b0;
    req_data  = '0;
    force_en  = 1'b0;
    force_val = '0;
    reg_m     = 8'hA5;

    // reset then idle
    cyc();
    cyc();
    chk("rst_clrn", ClrN, 1'b0);
    chk("rst_enbar", Enbar, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, '0);
    chk("rst_pulses", {done, clr_done, err}, '0);
    chk("rst_new_data", new_data, '0);
    Clr = 1'b0;
    cyc();
    chk("post_rst_clrn", ClrN, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_reg", register_q, '0);

    // single load for requester 2
    put(2, 8'h5A);
    req = 4'b0100;
    do_load(rr_pick(req, ptr_m), 8'h5A, 1'b0, '0);
    cyc();
    chk("done_pulse_width", done, '0);
    chk("idle_enbar", Enbar, 1'b1);

    // round-robin with all four held, starting from a fresh pointer
    Clr = 1'b1;
    cyc();
    Clr   = 1'b0;
    ptr_m = 0;
    put(0, 8'h11); put(1, 8'h22); put(2, 8'h33); put(3, 8'h44);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w = rr_pick(req, ptr_m);
      chk("rr_order", w, g % N);
      do_load(w, dat_of(w), 1'b0, '0);
      req = 4'b1111;
    end

    // clear wins over a simultaneous load request
    req     = 4'b0001;
    clr_req = 1'b1;
    chk("pre_clear_reg", register_q, 8'h11);
    do_clear();
    do_load(rr_pick(req, ptr_m), 8'h11, 1'b0, '0);

    // readback fault on requester 1, then requester 0 is served
    put(1, 8'h0F);
    req = 4'b0011;
    w = rr_pick(req, ptr_m);
    chk("fault_winner", w, 1);
    do_load(w, 8'h0F, 1'b1, '0);
    w = rr_pick(req, ptr_m);
    do_load(w, dat_of(w), 1'b0, '0);

    // reset while Enbar is low
    put(2, 8'h77);
    req = 4'b0100;
    cyc();
    chk("pre_abort_gnt", gnt, 4'b0100);
    chk("pre_abort_enbar", Enbar, 1'b0);
    Clr = 1'b1;
    cyc();
    chk("abort_enbar", Enbar, 1'b1);
    chk("abort_clrn", ClrN, 1'b0);
    chk("abort_gnt", gnt, '0);
    chk("abort_pulses", {done, err, clr_done}, '0);
    chk("abort_busy", busy, 1'b0);
    Clr   = 1'b0;
    ptr_m = 0;
    put(0, 8'h3C);
    req = 4'b0101;
    while (req != '0) begin
      w = rr_pick(req, ptr_m);
      do_load(w, dat_of(w), 1'b0, '0);
    end

    // randomized traffic against the round-robin model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) put(i, W'($urandom_range(0, 255)));
      req         = N'($urandom_range(0, (1 << N) - 1));
      do_clr      = ($urandom_range(0, 4) == 0);
      allow_extra = 1'b1;
      clr_req     = do_clr;
      if (do_clr) do_clear();
      if (req == '0) begin
        cyc();
        chk("rand_idle_busy", busy, 1'b0);
        chk("rand_idle_gnt", gnt, '0);
      end
      while (req != '0) begin
        w  = rr_pick(req, ptr_m);
        ex = '0;
        if (allow_extra) begin
          ex = N'($urandom_range(0, (1 << N) - 1)) & ~req;
          allow_extra = 1'b0;
        end
        do_load(w, dat_of(w), $urandom_range(0, 5) == 0, ex);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
